// File: rtl/day10_line_parser_if.sv
// ---------------------------------------------------------------------------
// day10_line_parser_if
//   AXI-stream style ASCII character channel, one character per beat.
//
//   s_tdata  : 8-bit ASCII character
//   s_tvalid : producer has a character on s_tdata
//   s_tready : consumer accepts the character this cycle
//
//   master : character producer (drives data/valid)
//   slave  : character consumer (drives ready)
// ---------------------------------------------------------------------------
interface day10_line_parser_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        output s_tready
    );
endinterface

// File: rtl/day10_line_parser.sv
// ---------------------------------------------------------------------------
// day10_line_parser
//   Parses one machine description per text line, e.g.
//     [.##.] (3) (1,3) (2) {3,5,4,7}\n
//   into a light target pattern plus one toggle mask per button group, then
//   hands the machine to a downstream solver with a one-cycle start pulse.
//   Spaces and carriage returns are ignored everywhere; malformed or
//   oversized lines set a sticky error and are dropped up to the next '\n'.
//
//   clk           : clock, all state on rising edge
//   rst_n         : asynchronous active-low reset
//   s_axis        : ASCII character stream (slave side)
//   target_lights : bit i set when light i is '#'
//   num_lights    : light count of the emitted line
//   button_masks  : entry b bit i set when button b toggles light i
//   num_buttons   : button count of the emitted line
//   start         : one-cycle pulse, outputs carry a new machine from the
//                   following cycle until the next start
//   ready         : downstream solver can accept start
//   error         : sticky malformed-line flag, cleared only by reset
// ---------------------------------------------------------------------------
module day10_line_parser #(
    parameter int  MAX_NUM_LIGHTS  = 6,
    parameter int  MAX_NUM_BUTTONS = 6,
    localparam int LW = (MAX_NUM_LIGHTS  <= 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    localparam int BW = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    day10_line_parser_if.slave                              s_axis,
    output logic [MAX_NUM_LIGHTS-1:0]                       target_lights,
    output logic [LW-1:0]                                   num_lights,
    output logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  button_masks,
    output logic [BW-1:0]                                   num_buttons,
    output logic                                            start,
    input  logic                                            ready,
    output logic                                            error
);

    localparam logic [7:0] CH_LBRACK = 8'h5B; // [
    localparam logic [7:0] CH_RBRACK = 8'h5D; // ]
    localparam logic [7:0] CH_DOT    = 8'h2E; // .
    localparam logic [7:0] CH_HASH   = 8'h23; // #
    localparam logic [7:0] CH_LPAREN = 8'h28; // (
    localparam logic [7:0] CH_RPAREN = 8'h29; // )
    localparam logic [7:0] CH_COMMA  = 8'h2C; // ,
    localparam logic [7:0] CH_LBRACE = 8'h7B; // {
    localparam logic [7:0] CH_RBRACE = 8'h7D; // }
    localparam logic [7:0] CH_NL     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LIGHTS,
        ST_GROUPS,
        ST_BUTTON,
        ST_JOLT,
        ST_EOL,
        ST_EMIT,
        ST_DISCARD
    } state_t;

    state_t state, state_next;

    // Working copy of the line being parsed.
    logic [MAX_NUM_LIGHTS-1:0]                      w_lights;
    logic [LW-1:0]                                  w_nl;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] w_masks;
    logic [BW-1:0]                                  w_nb;
    logic [3:0]                                     idx_acc;
    logic                                           have_digit;
    logic                                           tready_en;

    // Per-character actions decoded by the FSM.
    logic clr_work, add_light, add_digit, begin_button;
    logic commit_idx, end_button, set_error, do_emit, bad;

    logic [7:0]                ch;
    logic                      hs, is_skip, is_nl, is_digit;
    logic                      lights_full, buttons_full, idx_out_of_range;
    logic [7:0]                idx_prod;
    logic [3:0]                idx_next;
    logic [MAX_NUM_LIGHTS-1:0] light_onehot, idx_onehot;

    assign ch       = s_axis.s_tdata;
    // tready_en keeps s_tready low while reset is held and for the edge that
    // follows its release.
    assign s_axis.s_tready = tready_en && (state != ST_EMIT);
    assign hs       = s_axis.s_tvalid && s_axis.s_tready;
    assign is_skip  = (ch == CH_SPACE) || (ch == CH_CR);
    assign is_nl    = (ch == CH_NL);
    assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);

    assign lights_full      = (32'(w_nl) == MAX_NUM_LIGHTS);
    assign buttons_full     = (32'(w_nb) == MAX_NUM_BUTTONS);
    assign idx_out_of_range = (32'(idx_acc) >= 32'(w_nl));

    // Decimal accumulate; ASCII digits carry their value in the low nibble.
    // Largest product is 15*10+9 = 159, so 8 bits never wrap.
    assign idx_prod = ({4'd0, idx_acc} * 8'd10) + {4'd0, ch[3:0]};
    assign idx_next = (idx_prod > 8'd15) ? 4'hF : idx_prod[3:0];

    always_comb begin
        light_onehot = '0;
        idx_onehot   = '0;
        for (int i = 0; i < MAX_NUM_LIGHTS; i++) begin
            light_onehot[i] = (32'(w_nl) == i);
            idx_onehot[i]   = (32'(idx_acc) == i);
        end
    end

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state is written with <= so every register
            // samples pre-edge values, independent of statement order.
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and action decode
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next   = state;
        clr_work     = 1'b0;
        add_light    = 1'b0;
        add_digit    = 1'b0;
        begin_button = 1'b0;
        commit_idx   = 1'b0;
        end_button   = 1'b0;
        set_error    = 1'b0;
        do_emit      = 1'b0;
        bad          = 1'b0;

        if (state == ST_EMIT) begin
            if (ready) begin
                do_emit    = 1'b1;
                state_next = ST_IDLE;
            end
        end else if (hs && !is_skip) begin
            case (state)
                ST_IDLE: begin
                    if (ch == CH_LBRACK) begin
                        clr_work   = 1'b1;
                        state_next = ST_LIGHTS;
                    end else if (!is_nl) begin
                        bad = 1'b1;
                    end
                end
                ST_LIGHTS: begin
                    if (ch == CH_DOT || ch == CH_HASH) begin
                        if (lights_full) bad = 1'b1;
                        else             add_light = 1'b1;
                    end else if (ch == CH_RBRACK) begin
                        if (w_nl == '0) bad = 1'b1;
                        else            state_next = ST_GROUPS;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_GROUPS: begin
                    if (ch == CH_LPAREN) begin
                        if (buttons_full) begin
                            bad = 1'b1;
                        end else begin
                            begin_button = 1'b1;
                            state_next   = ST_BUTTON;
                        end
                    end else if (ch == CH_LBRACE) begin
                        state_next = ST_JOLT;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_BUTTON: begin
                    if (is_digit) begin
                        add_digit = 1'b1;
                    end else if (ch == CH_COMMA || ch == CH_RPAREN) begin
                        if (!have_digit || idx_out_of_range) begin
                            bad = 1'b1;
                        end else begin
                            commit_idx = 1'b1;
                            if (ch == CH_RPAREN) begin
                                end_button = 1'b1;
                                state_next = ST_GROUPS;
                            end
                        end
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_JOLT: begin
                    if (ch == CH_RBRACE) state_next = ST_EOL;
                    else if (is_nl)      bad = 1'b1;
                end
                ST_EOL: begin
                    if (is_nl) state_next = ST_EMIT;
                    else       bad = 1'b1;
                end
                ST_DISCARD: begin
                    if (is_nl) state_next = ST_IDLE;
                end
                default: ;
            endcase

            // A '\n' that breaks a line already ends it, so skip DISCARD
            // and let the next line start cleanly.
            if (bad) begin
                set_error  = 1'b1;
                state_next = is_nl ? ST_IDLE : ST_DISCARD;
            end
        end
    end

    assign start = do_emit;

    // ---------------------------------------------------------------------
    // Working and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the mask arrays are plain flops, not RAM, so they are
            // reset along with everything else; downstream relies on unused
            // entries reading as zero.
            tready_en     <= 1'b0;
            error         <= 1'b0;
            w_lights      <= '0;
            w_nl          <= '0;
            w_masks       <= '0;
            w_nb          <= '0;
            idx_acc       <= '0;
            have_digit    <= 1'b0;
            target_lights <= '0;
            num_lights    <= '0;
            button_masks  <= '0;
            num_buttons   <= '0;
        end else begin
            tready_en <= 1'b1;

            if (set_error) error <= 1'b1;

            if (clr_work) begin
                w_lights   <= '0;
                w_nl       <= '0;
                w_masks    <= '0;
                w_nb       <= '0;
                idx_acc    <= '0;
                have_digit <= 1'b0;
            end

            if (add_light) begin
                if (ch == CH_HASH) w_lights <= w_lights | light_onehot;
                w_nl <= w_nl + LW'(1);
            end

            if (begin_button) begin
                idx_acc    <= '0;
                have_digit <= 1'b0;
            end

            if (add_digit) begin
                idx_acc    <= idx_next;
                have_digit <= 1'b1;
            end

            if (commit_idx) begin
                // OR-in keeps a repeated index idempotent.
                for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
                    if (32'(w_nb) == b) w_masks[b] <= w_masks[b] | idx_onehot;
                end
                idx_acc    <= '0;
                have_digit <= 1'b0;
            end

            if (end_button) w_nb <= w_nb + BW'(1);

            if (do_emit) begin
                target_lights <= w_lights;
                num_lights    <= w_nl;
                button_masks  <= w_masks;
                num_buttons   <= w_nb;
            end
        end
    end

endmodule

// File: tb/tb_day10_line_parser.sv
// ---------------------------------------------------------------------------
// tb_day10_line_parser
//   Directed self-checking bench for day10_line_parser with the default
//   6-light / 6-button configuration.
// ---------------------------------------------------------------------------
module tb_day10_line_parser;

    logic             clk;
    logic             rst_n;
    logic             ready;
    logic [5:0]       target_lights;
    logic [2:0]       num_lights;
    logic [5:0][5:0]  button_masks;
    logic [2:0]       num_buttons;
    logic             start;
    logic             error;

    int checks      = 0;
    int failures    = 0;
    int start_count = 0;
    int exp_starts  = 0;

    day10_line_parser_if bus ();

    day10_line_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis        (bus),
        .target_lights (target_lights),
        .num_lights    (num_lights),
        .button_masks  (button_masks),
        .num_buttons   (num_buttons),
        .start         (start),
        .ready         (ready),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start === 1'b1) start_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected machines, hand-derived from the line text.
    // L29: [.##.] (3) (1,3) (2) (2,3) (0,2) (0,1)
    localparam logic [5:0]  L29_TGT   = 6'b000110;
    localparam logic [35:0] L29_MASKS = {6'b000011, 6'b000101, 6'b001100,
                                         6'b000100, 6'b001010, 6'b001000};
    // L2: [#....#] (05,00) (01,1)
    localparam logic [5:0]  L2_TGT    = 6'b100001;
    localparam logic [35:0] L2_MASKS  = {24'd0, 6'b000010, 6'b100001};
    // L3: [#.#] (0,2) (1)
    localparam logic [5:0]  L3_TGT    = 6'b000101;
    localparam logic [35:0] L3_MASKS  = {24'd0, 6'b000010, 6'b000101};

    localparam string LINE29 = "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n";
    localparam string LINE2  = "[#....#] (05,00) (01,1) {}\n";
    localparam string LINE3  = "[#.#] (0,2) (1) {9}\n";

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one character and holds it until the handshake edge.
    task automatic send_char(input byte c, input int gap);
        logic accept;
        int   waited;
        if (gap > 0) tick(gap);
        bus.s_tdata  = c;
        bus.s_tvalid = 1'b1;
        accept = 1'b0;
        waited = 0;
        while (!accept && waited < 50) begin
            @(negedge clk);
            accept = bus.s_tready;
            waited++;
        end
        if (!accept) begin
            check("handshake_timeout", 64'(accept), 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.s_tvalid = 1'b0;
    endtask

    task automatic send_line(input string s, input bit gaps);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            send_char(c, gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic expect_machine(input string pfx, input logic [5:0] tgt,
                                  input logic [2:0] nl, input logic [35:0] masks,
                                  input logic [2:0] nb);
        check({pfx, ".target"},      64'(target_lights), 64'(tgt));
        check({pfx, ".num_lights"},  64'(num_lights),    64'(nl));
        check({pfx, ".masks"},       64'(button_masks),  64'(masks));
        check({pfx, ".num_buttons"}, 64'(num_buttons),   64'(nb));
    endtask

    initial begin
        int stall_bad;

        rst_n        = 1'b0;
        ready        = 1'b1;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h00;

        // Reset state.
        tick(3);
        @(negedge clk);
        check("rst.tready", 64'(bus.s_tready), 64'd0);
        check("rst.start",  64'(start),        64'd0);
        check("rst.error",  64'(error),        64'd0);
        expect_machine("rst", 6'd0, 3'd0, 36'd0, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst.tready", 64'(bus.s_tready), 64'd1);
        @(posedge clk);
        #1;

        // Reference example line, solver ready.
        send_line(LINE29, 1'b0);
        exp_starts++;
        tick(3);
        check("l29.starts", 64'(start_count), 64'(exp_starts));
        check("l29.error",  64'(error),       64'd0);
        expect_machine("l29", L29_TGT, 3'd4, L29_MASKS, 3'd6);

        // Multi-digit indices with leading zeros and a duplicate index.
        send_line(LINE2, 1'b0);
        exp_starts++;
        tick(3);
        check("l2.starts", 64'(start_count), 64'(exp_starts));
        expect_machine("l2", L2_TGT, 3'd6, L2_MASKS, 3'd2);

        // Back-pressure: solver busy for 10 cycles after the newline.
        ready = 1'b0;
        send_line(LINE29, 1'b0);
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.s_tready !== 1'b0 || start !== 1'b0) stall_bad++;
        end
        check("stall.quiet", 64'(stall_bad), 64'd0);
        expect_machine("stall.held", L2_TGT, 3'd6, L2_MASKS, 3'd2);
        @(posedge clk);
        #1;
        ready = 1'b1;
        @(negedge clk);
        check("stall.start", 64'(start), 64'd1);
        exp_starts++;
        tick(3);
        check("stall.starts", 64'(start_count), 64'(exp_starts));
        expect_machine("stall", L29_TGT, 3'd4, L29_MASKS, 3'd6);

        send_line(LINE3, 1'b0);
        exp_starts++;
        tick(3);
        expect_machine("l3", L3_TGT, 3'd3, L3_MASKS, 3'd2);

        // Blank line is ignored.
        send_line("\n", 1'b0);
        tick(3);
        check("blank.starts", 64'(start_count), 64'(exp_starts));
        check("blank.error",  64'(error),       64'd0);

        // Index out of range, then a good line.
        send_line("[#.] (2) {1}\n", 1'b0);
        tick(3);
        check("oor.error",  64'(error),       64'd1);
        check("oor.starts", 64'(start_count), 64'(exp_starts));
        expect_machine("oor.held", L3_TGT, 3'd3, L3_MASKS, 3'd2);
        send_line(LINE29, 1'b0);
        exp_starts++;
        tick(3);
        check("after_oor.starts", 64'(start_count), 64'(exp_starts));
        expect_machine("after_oor", L29_TGT, 3'd4, L29_MASKS, 3'd6);

        // Seven button groups exceeds the limit.
        send_line("[.##.] (0) (1) (2) (3) (0) (1) (2) {1}\n", 1'b0);
        tick(3);
        check("btn7.starts", 64'(start_count), 64'(exp_starts));
        check("btn7.error",  64'(error),       64'd1);
        send_line(LINE3, 1'b0);
        exp_starts++;
        tick(3);
        check("after_btn7.starts", 64'(start_count), 64'(exp_starts));
        expect_machine("after_btn7", L3_TGT, 3'd3, L3_MASKS, 3'd2);

        // Seven lights, then zero lights.
        send_line("[#######] {1}\n", 1'b0);
        send_line("[] {1}\n", 1'b0);
        tick(3);
        check("badlights.starts", 64'(start_count), 64'(exp_starts));
        expect_machine("badlights.held", L3_TGT, 3'd3, L3_MASKS, 3'd2);

        // Random valid gaps and CRLF ending.
        send_line("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\015\n", 1'b1);
        exp_starts++;
        tick(3);
        check("crlf.starts", 64'(start_count), 64'(exp_starts));
        expect_machine("crlf", L29_TGT, 3'd4, L29_MASKS, 3'd6);

        // Reset in the middle of a line.
        send_line("[.#", 1'b0);
        rst_n = 1'b0;
        tick(2);
        @(negedge clk);
        check("midrst.tready", 64'(bus.s_tready), 64'd0);
        check("midrst.error",  64'(error),        64'd0);
        expect_machine("midrst", 6'd0, 3'd0, 36'd0, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        check("midrst.starts", 64'(start_count), 64'(exp_starts));
        send_line(LINE3, 1'b0);
        exp_starts++;
        tick(3);
        check("after_rst.starts", 64'(start_count), 64'(exp_starts));
        check("after_rst.error",  64'(error),       64'd0);
        expect_machine("after_rst", L3_TGT, 3'd3, L3_MASKS, 3'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
